vga_scan_generator: RTL and testbench

//  Drives the pixel-coordinate side of the display path: generates 640x480@60 VGA timing, publishes
//  the current scan position (x, y) to the combinational renderer, and captures the renderer's colour
//  one pixel later. Colour and sync leave through one shared register stage, so they are pixel-aligned at the pins.

---
 rtl/vga_scan_if.sv | 38 +++
 rtl/vga_scan_generator.sv | 117 +++++++++++
 tb/tb_vga_scan_generator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// ---------------------------------------------------------------------------
// vga_scan_if
//   Bundles the signals between the VGA scan generator, the pixel renderer
//   and the VGA connector.
//
//   master modport (scan generator):
//      x, y        out  current scan position handed to the renderer
//      r, g, b     in   renderer colour for (x, y), combinational in x/y
//      vgaR/G/B    out  registered colour to the DAC
//      hsync/vsync out  registered sync pulses
//      visible     out  scan position lies inside the active picture
//      frameStart  out  one-clk pulse on the wrap to (0,0)
//   slave modport (renderer / observer): mirror image of master.
// ---------------------------------------------------------------------------
interface vga_scan_if;
   logic [10:0] x;
   logic [10:0] y;
   logic [2:0]  r;
   logic [2:0]  g;
   logic [2:0]  b;
   logic [2:0]  vgaR;
   logic [2:0]  vgaG;
   logic [2:0]  vgaB;
   logic        hsync;
   logic        vsync;
   logic        visible;
   logic        frameStart;

   modport master (
      output x, y, vgaR, vgaG, vgaB, hsync, vsync, visible, frameStart,
      input  r, g, b
   );

   modport slave (
      input  x, y, vgaR, vgaG, vgaB, hsync, vsync, visible, frameStart,
      output r, g, b
   );
endinterface

// File: rtl/vga_scan_generator.sv
// ---------------------------------------------------------------------------
// vga_scan_generator
//   Generates VGA raster timing (640x480@60 by default), presents the current
//   scan position to a combinational renderer and registers the returned
//   colour together with hsync/vsync, so colour and sync leave the chip in the
//   same register stage and stay pixel-aligned.
//
//   Ports:
//      clk   in   system clock
//      rst   in   asynchronous reset, active-high
//      scan  master side of vga_scan_if (x/y out, r/g/b in, DAC/sync out)
// ---------------------------------------------------------------------------
module vga_scan_generator #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   vga_scan_if.master scan
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   // A one-bit divider is kept even for CLK_DIV=1; its terminal value is then
   // 0, so it never leaves 0 and tick stays permanently high.
   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [10:0]      h_count_q, h_count_d;
   logic [10:0]      v_count_q, v_count_d;
   logic [2:0]       red_q, red_d;
   logic [2:0]       green_q, green_d;
   logic [2:0]       blue_q, blue_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             tick;
   logic             visible;
   logic             h_wrap;
   logic             v_wrap;

   always_comb begin
      tick      = (div_q == DIV_LAST);
      div_d     = tick ? '0 : div_q + DIV_W'(1);

      h_wrap    = (h_count_q == H_LAST);
      v_wrap    = (v_count_q == V_LAST);
      h_count_d = h_wrap ? 11'd0 : h_count_q + 11'd1;
      v_count_d = v_count_q;
      if (h_wrap) begin
         v_count_d = v_wrap ? 11'd0 : v_count_q + 11'd1;
      end

      visible   = (h_count_q < H_VIS) && (v_count_q < V_VIS);

      // Output stage samples the position currently on x/y, i.e. before the
      // counters advance on this tick, which gives the one-pixel latency.
      red_d     = visible ? scan.r : 3'd0;
      green_d   = visible ? scan.g : 3'd0;
      blue_d    = visible ? scan.b : 3'd0;
      hsync_d   = ((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d   = ((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         h_count_q <= 11'd0;
         v_count_q <= 11'd0;
         red_q     <= 3'd0;
         green_q   <= 3'd0;
         blue_q    <= 3'd0;
         hsync_q   <= ~SYNC_POL;
         vsync_q   <= ~SYNC_POL;
      end else begin
         div_q <= div_d;
         if (tick) begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
         end
      end
   end

   assign scan.x          = h_count_q;
   assign scan.y          = v_count_q;
   assign scan.vgaR       = red_q;
   assign scan.vgaG       = green_q;
   assign scan.vgaB       = blue_q;
   assign scan.hsync      = hsync_q;
   assign scan.vsync      = vsync_q;
   assign scan.visible    = visible;
   assign scan.frameStart = tick && h_wrap && v_wrap;

endmodule

// File: tb/tb_vga_scan_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_generator
//   dut_a: CLK_DIV=2, active-low sync, full 800-pixel lines, 9-line frame
//          (4 visible, 1 front, 2 sync, 2 back) so whole frames stay short.
//          Line = 1600 clk, frame = 800*9*2 = 14400 clk, vsync on lines 5..6.
//   dut_b: CLK_DIV=1, active-high sync, full 800-pixel lines.
// ---------------------------------------------------------------------------
module tb_vga_scan_generator;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic [2:0] rgb_a = 3'd0;
   logic use_x = 1'b0;
   int cyc = 0;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_scan_if bus_a ();
   vga_scan_if bus_b ();

   assign bus_a.r = use_x ? bus_a.x[2:0] : rgb_a;
   assign bus_a.g = rgb_a;
   assign bus_a.b = rgb_a;
   assign bus_b.r = 3'd1;
   assign bus_b.g = 3'd0;
   assign bus_b.b = 3'd0;

   vga_scan_generator #(
      .CLK_DIV(2), .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst_a), .scan(bus_a)
   );

   vga_scan_generator #(
      .CLK_DIV(1), .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst_b), .scan(bus_b)
   );

   typedef struct {
      int         px;
      int         py;
      logic [2:0] rgb;
      logic       vis;
      logic [2:0] vga;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   // Called from a negedge; returns at the first negedge showing (px,py).
   task automatic wait_xy(input int px, input int py, input string tag);
      int n = 0;
      while (!(int'(bus_a.x) == px && int'(bus_a.y) == py) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40000) begin
         tests++;
         fails++;
         $display("FAIL %s: timeout waiting for x=%0d y=%0d, at x=%0d y=%0d",
                  tag, px, py, int'(bus_a.x), int'(bus_a.y));
      end
   endtask

   initial begin
      int n, errs, hi, prev, cnt7, cnt0, low, t0, t1, t_fs1, t_fs2, ticks, last_x, last_y, expv;

      vecs[0]  = '{0,   0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1};
      vecs[1]  = '{639, 0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1};
      vecs[2]  = '{640, 0, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1};
      vecs[3]  = '{655, 0, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1};
      vecs[4]  = '{656, 0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[5]  = '{751, 0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[6]  = '{752, 0, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1};
      vecs[7]  = '{100, 3, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1};
      vecs[8]  = '{100, 4, 3'd2, 1'b0, 3'd0, 1'b1, 1'b1};
      vecs[9]  = '{0,   5, 3'd7, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[10] = '{700, 6, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[11] = '{0,   7, 3'd7, 1'b0, 3'd0, 1'b1, 1'b1};
      vecs[12] = '{639, 8, 3'd4, 1'b0, 3'd0, 1'b1, 1'b1};

      // ---------------- reset state of dut_a ----------------
      rgb_a = 3'd7;
      repeat (3) @(negedge clk);
      check("rst_x", int'(bus_a.x), 0);
      check("rst_y", int'(bus_a.y), 0);
      check("rst_rgb", int'({bus_a.vgaR, bus_a.vgaG, bus_a.vgaB}), 0);
      check("rst_hsync", int'(bus_a.hsync), 1);
      check("rst_vsync", int'(bus_a.vsync), 1);
      check("rst_visible", int'(bus_a.visible), 1);
      check("rst_framestart", int'(bus_a.frameStart), 0);

      // ---------------- dut_b: CLK_DIV=1, active-high sync ----------------
      rst_b = 1'b0;
      prev = int'(bus_b.x);
      errs = 0;
      hi = 0;
      repeat (800) begin
         @(negedge clk);
         if (int'(bus_b.x) != ((prev == 799) ? 0 : prev + 1)) errs++;
         if (bus_b.hsync) hi++;
         prev = int'(bus_b.x);
      end
      check("b_x_step_errors", errs, 0);
      check("b_hsync_high_clk", hi, 96);

      // ---------------- dut_a: table of probe points ----------------
      rst_a = 1'b0;
      for (int i = 0; i < 13; i++) begin
         rgb_a = vecs[i].rgb;
         wait_xy(vecs[i].px, vecs[i].py, $sformatf("vec%0d_wait", i));
         check($sformatf("vec%0d_visible", i), int'(bus_a.visible), int'(vecs[i].vis));
         n = 0;
         while (int'(bus_a.x) == vecs[i].px && n < 8) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("vec%0d_rgb", i), int'({bus_a.vgaR, bus_a.vgaG, bus_a.vgaB}),
               int'({vecs[i].vga, vecs[i].vga, vecs[i].vga}));
         check($sformatf("vec%0d_hsync", i), int'(bus_a.hsync), int'(vecs[i].hs));
         check($sformatf("vec%0d_vsync", i), int'(bus_a.vsync), int'(vecs[i].vs));
      end

      // ---------------- frame wrap at (799, last line) ----------------
      wait_xy(798, 8, "wrap_wait");
      n = 0;
      while (int'(bus_a.x) != 799 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("wrap_x_before", int'(bus_a.x), 799);
      check("wrap_fs_early", int'(bus_a.frameStart), 0);
      @(negedge clk);
      check("wrap_fs_pulse", int'(bus_a.frameStart), 1);
      t_fs1 = cyc;
      @(negedge clk);
      check("wrap_x_after", int'(bus_a.x), 0);
      check("wrap_y_after", int'(bus_a.y), 0);
      check("wrap_fs_width", int'(bus_a.frameStart), 0);

      // ---------------- visible line colour run ----------------
      rgb_a = 3'd7;
      cnt7 = 0;
      cnt0 = 0;
      repeat (1600) begin
         @(negedge clk);
         if (bus_a.vgaR == 3'd7) cnt7++;
         if (bus_a.vgaR == 3'd0) cnt0++;
      end
      check("line_vgaR_7_clk", cnt7, 1280);
      check("line_vgaR_0_clk", cnt0, 320);

      // ---------------- hsync period / width ----------------
      n = 0;
      prev = int'(bus_a.hsync);
      while (!(prev == 1 && bus_a.hsync == 1'b0) && n < 4000) begin
         prev = int'(bus_a.hsync);
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      low = 0;
      while (bus_a.hsync == 1'b0 && low < 4000) begin
         low++;
         @(negedge clk);
      end
      check("hsync_low_clk", low, 192);
      n = 0;
      prev = int'(bus_a.hsync);
      while (!(prev == 1 && bus_a.hsync == 1'b0) && n < 4000) begin
         prev = int'(bus_a.hsync);
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      check("hsync_period_clk", t1 - t0, 1600);

      // ---------------- vsync position / width, frame period ----------------
      n = 0;
      prev = int'(bus_a.vsync);
      while (!(prev == 1 && bus_a.vsync == 1'b0) && n < 20000) begin
         prev = int'(bus_a.vsync);
         @(negedge clk);
         n++;
      end
      check("vsync_start_line", int'(bus_a.y), 5);
      low = 0;
      while (bus_a.vsync == 1'b0 && low < 20000) begin
         low++;
         @(negedge clk);
      end
      check("vsync_low_clk", low, 3200);
      n = 0;
      while (bus_a.frameStart == 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      t_fs2 = cyc;
      check("frame_period_clk", t_fs2 - t_fs1, 14400);

      // ---------------- async reset mid-line, visible colour ----------------
      rgb_a = 3'd7;
      wait_xy(300, 2, "rst1_wait");
      check("rst1_pre_vgaR", int'(bus_a.vgaR), 7);
      #2 rst_a = 1'b1;
      #1;
      check("rst1_x", int'(bus_a.x), 0);
      check("rst1_y", int'(bus_a.y), 0);
      check("rst1_rgb", int'({bus_a.vgaR, bus_a.vgaG, bus_a.vgaB}), 0);
      check("rst1_visible", int'(bus_a.visible), 1);
      check("rst1_fs", int'(bus_a.frameStart), 0);
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      check("rst1_x_edge1", int'(bus_a.x), 0);
      @(negedge clk);
      check("rst1_x_edge2", int'(bus_a.x), 1);

      // ---------------- renderer r = x[2:0] ----------------
      use_x = 1'b1;
      wait_xy(600, 3, "rx_wait");
      last_x = int'(bus_a.x);
      last_y = int'(bus_a.y);
      errs = 0;
      ticks = 0;
      repeat (2000) begin
         @(negedge clk);
         if (int'(bus_a.x) != last_x) begin
            ticks++;
            expv = (last_x < 640 && last_y < 4) ? (last_x % 8) : 0;
            if (int'(bus_a.vgaR) != expv) errs++;
            last_x = int'(bus_a.x);
            last_y = int'(bus_a.y);
         end
      end
      use_x = 1'b0;
      check("rx_vgaR_errors", errs, 0);
      check("rx_ticks", ticks, 1000);

      // ---------------- async reset while both syncs asserted ----------------
      wait_xy(700, 5, "rst2_wait");
      check("rst2_pre_hsync", int'(bus_a.hsync), 0);
      check("rst2_pre_vsync", int'(bus_a.vsync), 0);
      #2 rst_a = 1'b1;
      #1;
      check("rst2_hsync", int'(bus_a.hsync), 1);
      check("rst2_vsync", int'(bus_a.vsync), 1);
      check("rst2_xy", int'({bus_a.x, bus_a.y}), 0);
      @(negedge clk);
      rst_a = 1'b0;
      n = 0;
      while (int'(bus_a.y) != 1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("rst2_first_line_clk", n, 1600);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
